// File: rtl/mega_ram_arbiter_if.sv
// Bus bundle between the CPU/DMA masters, the arbiter and the mega_ram array.
// slave = arbiter view, master = environment (masters + RAM) view.
interface mega_ram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in;
  logic [DW-1:0] cpu_d_out;
  logic          cpu_wait;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_a;
  logic [DW-1:0] dma_d_in;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_d_out;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d_in;
  logic [DW-1:0] ram_d_out;

  modport slave (
    input  cpu_we, cpu_re, cpu_a, cpu_d_in,
    input  dma_req, dma_we, dma_a, dma_d_in,
    input  ram_d_out,
    output cpu_d_out, cpu_wait,
    output dma_gnt, dma_rvalid, dma_d_out,
    output ram_we, ram_re, ram_a, ram_d_in
  );

  modport master (
    output cpu_we, cpu_re, cpu_a, cpu_d_in,
    output dma_req, dma_we, dma_a, dma_d_in,
    output ram_d_out,
    input  cpu_d_out, cpu_wait,
    input  dma_gnt, dma_rvalid, dma_d_out,
    input  ram_we, ram_re, ram_a, ram_d_in
  );
endinterface

// File: rtl/mega_ram_arbiter.sv
// CPU-priority two-master arbiter for the single-port mega_ram, with DMA
// starvation guard and 1-cycle read-return steering.
module mega_ram_arbiter #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mega_ram_arbiter_if.slave  bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       rd_vld_q, rd_vld_d;
  logic       rd_own_q, rd_own_d;
  logic       cpu_act, cpu_own, dma_own;

  logic [ADDR_BUS_WIDTH-1:0] ram_a_d;
  logic [DATA_BUS_WIDTH-1:0] ram_wd_d;
  logic                      ram_we_d;

  always_comb begin
    cpu_act  = bus.cpu_we | bus.cpu_re;
    dma_own  = bus.dma_req &
               (!cpu_act || (starve_q == LIMIT));
    cpu_own  = cpu_act & !dma_own;
    ram_a_d  = bus.cpu_a;
    ram_wd_d = bus.cpu_d_in;
    ram_we_d = 1'b0;
    rd_vld_d = 1'b0;
    rd_own_d = dma_own;
    starve_d = starve_q;
    unique case (1'b1)
      dma_own: begin
        ram_a_d  = bus.dma_a;
        ram_wd_d = bus.dma_d_in;
        ram_we_d = bus.dma_we;
        rd_vld_d = !bus.dma_we;
      end
      cpu_own: begin
        ram_we_d = bus.cpu_we;
        rd_vld_d = bus.cpu_re;
      end
      default: ;
    endcase
    // a denied request ages; a grant or a dropped request forgives
    if (!bus.dma_req || dma_own)
      starve_d = '0;
    else if (starve_q != LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign bus.ram_a      = ram_a_d;
  assign bus.ram_d_in   = ram_wd_d;
  assign bus.ram_we     = rst_n & ram_we_d;
  assign bus.dma_gnt    = rst_n & dma_own;
  assign bus.cpu_wait   = rst_n & cpu_act & dma_own;
  assign bus.ram_re     = rd_vld_q;
  assign bus.dma_rvalid = rd_vld_q & rd_own_q;
  assign bus.cpu_d_out  = (rd_vld_q && !rd_own_q) ?
                          bus.ram_d_out : '0;
  assign bus.dma_d_out  = (rd_vld_q && rd_own_q) ?
                          bus.ram_d_out : '0;
endmodule

// File: tb/tb_mega_ram_arbiter.sv
// Directed scoreboard bench for mega_ram_arbiter with a behavioural
// registered-read RAM behind it.
module tb_mega_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] cq[$];
  logic [7:0] dq[$];

  mega_ram_arbiter_if #(.AW(13), .DW(8)) bus ();

  mega_ram_arbiter #(
    .ADDR_BUS_WIDTH(13),
    .DATA_BUS_WIDTH(8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];
  logic [7:0] rdata;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d_in;
    rdata <= mem[bus.ram_a];
  end
  assign bus.ram_d_out = bus.ram_re ? rdata : 8'h00;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cw, input logic cr,
                       input logic [12:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw,
                       input logic [12:0] da, input logic [7:0] dd);
    bus.cpu_we   = cw;
    bus.cpu_re   = cr;
    bus.cpu_a    = ca;
    bus.cpu_d_in = cd;
    bus.dma_req  = dr;
    bus.dma_we   = dw;
    bus.dma_a    = da;
    bus.dma_d_in = dd;
  endtask

  // one bus cycle: check grant/wait, queue expected reads, check returns
  task automatic step(input logic cw, input logic cr,
                      input logic [12:0] ca, input logic [7:0] cd,
                      input logic dr, input logic dw,
                      input logic [12:0] da, input logic [7:0] dd,
                      input logic eg, input logic ew,
                      input logic [7:0] ecd, input logic [7:0] edd);
    logic [7:0] e;
    drive(cw, cr, ca, cd, dr, dw, da, dd);
    #1;
    chk("dma_gnt", 16'(bus.dma_gnt), 16'(eg));
    chk("cpu_wait", 16'(bus.cpu_wait), 16'(ew));
    if (cr && !ew && !(eg && !(cw || cr))) cq.push_back(ecd);
    if (dr && eg && !dw) dq.push_back(edd);
    @(posedge clk);
    #1;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("cpu_d_out", 16'(bus.cpu_d_out), 16'(e));
    end else begin
      chk("cpu_d_out_idle", 16'(bus.cpu_d_out), 16'h0);
    end
    if (dq.size() > 0) begin
      e = dq.pop_front();
      chk("dma_rvalid", 16'(bus.dma_rvalid), 16'h1);
      chk("dma_d_out", 16'(bus.dma_d_out), 16'(e));
    end else begin
      chk("dma_rvalid_idle", 16'(bus.dma_rvalid), 16'h0);
      chk("dma_d_out_idle", 16'(bus.dma_d_out), 16'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b1, 13'h5, 8'h77, 1'b1, 1'b0, 13'h6, 8'h00);
    #3;
    chk("rst_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("rst_cpu_wait", 16'(bus.cpu_wait), 16'h0);
    chk("rst_ram_we", 16'(bus.ram_we), 16'h0);
    chk("rst_ram_re", 16'(bus.ram_re), 16'h0);
    chk("rst_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);
    chk("rst_cpu_d_out", 16'(bus.cpu_d_out), 16'h0);
    chk("rst_dma_d_out", 16'(bus.dma_d_out), 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    rst_n = 1'b1;

    // preload through both masters
    step(1, 0, 13'h0010, 8'h3C, 0, 0, 13'h0, 8'h0, 0, 0, 8'h0, 8'h0);
    step(1, 0, 13'h0001, 8'h11, 0, 0, 13'h0, 8'h0, 0, 0, 8'h0, 8'h0);
    step(0, 0, 13'h0, 8'h0, 1, 1, 13'h0002, 8'h22, 1, 0, 8'h0, 8'h0);
    step(0, 0, 13'h0, 8'h0, 1, 1, 13'h0040, 8'h55, 1, 0, 8'h0, 8'h0);

    // CPU write then read back
    step(1, 0, 13'h0123, 8'hA5, 0, 0, 13'h0, 8'h0, 0, 0, 8'h0, 8'h0);
    step(0, 1, 13'h0123, 8'h00, 0, 0, 13'h0, 8'h0, 0, 0, 8'hA5, 8'h0);

    // DMA-only read
    step(0, 0, 13'h0, 8'h0, 1, 0, 13'h0010, 8'h0, 1, 0, 8'h0, 8'h3C);

    // starvation: DMA forced in on the 5th contended cycle
    for (int i = 0; i < 4; i++)
      step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0002, 8'h0, 0, 0, 8'h11, 8'h0);
    step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0002, 8'h0, 1, 1, 8'h0, 8'h22);
    step(0, 1, 13'h0001, 8'h0, 0, 0, 13'h0, 8'h0, 0, 0, 8'h11, 8'h0);

    // alternating masters, returns steered to issuer
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 13'h0001, 8'h0, 0, 0, 13'h0, 8'h0, 0, 0, 8'h11, 8'h0);
      step(0, 0, 13'h0, 8'h0, 1, 0, 13'h0002, 8'h0, 1, 0, 8'h0, 8'h22);
    end

    // read-modify-write returns old data
    step(1, 1, 13'h0040, 8'hAA, 0, 0, 13'h0, 8'h0, 0, 0, 8'h55, 8'h0);
    step(0, 1, 13'h0040, 8'h00, 0, 0, 13'h0, 8'h0, 0, 0, 8'hAA, 8'h0);

    // build up starvation, then reset with a DMA read in flight
    step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0002, 8'h0, 0, 0, 8'h11, 8'h0);
    step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0002, 8'h0, 0, 0, 8'h11, 8'h0);
    drive(0, 0, 13'h0, 8'h0, 1, 0, 13'h0002, 8'h0);
    #1;
    chk("pre_rst_gnt", 16'(bus.dma_gnt), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("in_rst_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("in_rst_ram_we", 16'(bus.ram_we), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_discard_rvalid", 16'(bus.dma_rvalid), 16'h0);
    chk("rst_discard_d_out", 16'(bus.dma_d_out), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_starve_cnt", 16'(dut.starve_q), 16'h0);
    chk("rst_ram_re", 16'(bus.ram_re), 16'h0);
    step(0, 0, 13'h0, 8'h0, 0, 0, 13'h0, 8'h0, 0, 0, 8'h0, 8'h0);

    // starve counter restarts from zero after reset
    for (int i = 0; i < 4; i++)
      step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0010, 8'h0, 0, 0, 8'h11, 8'h0);
    step(0, 1, 13'h0001, 8'h0, 1, 0, 13'h0010, 8'h0, 1, 1, 8'h0, 8'h3C);
    step(0, 0, 13'h0, 8'h0, 0, 0, 13'h0, 8'h0, 0, 0, 8'h0, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
